// File: rtl/multi_ff_sync_filter.sv
// Multi-flop synchroniser for WIDTH asynchronous inputs with a per-channel
// glitch filter and registered rise/fall edge pulses.
module multi_ff_sync_filter #(
  parameter int               WIDTH       = 8,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] NRST_VAL    = '0,
  parameter int               FILT_CYCLES = 1
) (
  input  logic             clkin,
  input  logic             nrst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_edge
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("multi_ff_sync_filter: STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("multi_ff_sync_filter: FILT_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;
  logic [WIDTH-1:0] sync_out;

  always_comb begin
    sync_d[0] = data_in;
    for (int s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];

  // A channel only flips once FILT_CYCLES consecutive samples disagree with it.
  always_comb begin
    data_d = data_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_out[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        data_d[i] = sync_out[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync_out[i];
        fall_d[i] = ~sync_out[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clkin) begin
    if (!nrst_in) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= NRST_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      data_q <= NRST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign data_out   = data_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_edge   = any_q;

endmodule

// File: tb/tb_multi_ff_sync_filter.sv
// Self-checking bench: two filter configurations driven by the same inputs,
// compared every cycle against a queue-based reference model plus directed checks.
module tb_multi_ff_sync_filter;

  logic       clkin;
  logic       nrst_in;
  logic [7:0] din;
  logic [7:0] dout_a, rise_a, fall_a;
  logic [7:0] dout_b, rise_b, fall_b;
  logic       any_a, any_b;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] pipe  [2][$];
  logic [7:0] shist [2][$];
  logic [7:0] exp_out  [2];
  logic [7:0] exp_rise [2];
  logic [7:0] exp_fall [2];
  logic       exp_any  [2];

  multi_ff_sync_filter #(
    .WIDTH(8), .STAGES(2), .NRST_VAL(8'hFF), .FILT_CYCLES(1)
  ) u_a (
    .clkin(clkin), .nrst_in(nrst_in), .data_in(din),
    .data_out(dout_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .any_edge(any_a)
  );

  multi_ff_sync_filter #(
    .WIDTH(8), .STAGES(3), .NRST_VAL(8'h00), .FILT_CYCLES(4)
  ) u_b (
    .clkin(clkin), .nrst_in(nrst_in), .data_in(din),
    .data_out(dout_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .any_edge(any_b)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  function automatic int st_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int fc_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] nv_of(input int k);
    return (k == 0) ? 8'hFF : 8'h00;
  endfunction

  // Input is seen at the output STAGES edges later; a bit flips once the last
  // FILT_CYCLES synced samples all disagree with the current output level.
  task automatic model_edge(input int k);
    logic [7:0] s;
    logic [7:0] flip;
    if (!nrst_in) begin
      pipe[k].delete();
      repeat (st_of(k)) pipe[k].push_back(nv_of(k));
      shist[k].delete();
      exp_out[k]  = nv_of(k);
      exp_rise[k] = '0;
      exp_fall[k] = '0;
      exp_any[k]  = 1'b0;
      return;
    end
    if (pipe[k].size() != st_of(k)) return;
    s = pipe[k][st_of(k)-1];
    void'(pipe[k].pop_back());
    pipe[k].push_front(din);
    shist[k].push_front(s);
    if (shist[k].size() > fc_of(k)) void'(shist[k].pop_back());
    flip = '0;
    if (shist[k].size() == fc_of(k)) begin
      flip = '1;
      for (int j = 0; j < shist[k].size(); j++) begin
        flip = flip & (shist[k][j] ^ exp_out[k]);
      end
    end
    exp_rise[k] = flip & ~exp_out[k];
    exp_fall[k] = flip & exp_out[k];
    exp_out[k]  = exp_out[k] ^ flip;
    exp_any[k]  = |flip;
  endtask

  always @(posedge clkin) begin
    model_edge(0);
    model_edge(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    checkOutput("a_out",  32'(dout_a), 32'(exp_out[0]));
    checkOutput("a_rise", 32'(rise_a), 32'(exp_rise[0]));
    checkOutput("a_fall", 32'(fall_a), 32'(exp_fall[0]));
    checkOutput("a_any",  32'(any_a),  32'(exp_any[0]));
    checkOutput("b_out",  32'(dout_b), 32'(exp_out[1]));
    checkOutput("b_rise", 32'(rise_b), 32'(exp_rise[1]));
    checkOutput("b_fall", 32'(fall_b), 32'(exp_fall[1]));
    checkOutput("b_any",  32'(any_b),  32'(exp_any[1]));
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
    check_all();
  endtask

  task automatic applyStimulus();
    if ($urandom_range(0, 3) == 0) din = din ^ 8'($urandom);
    nrst_in = ($urandom_range(0, 499) != 0);
    step();
  endtask

  initial begin
    nrst_in = 1'b0;
    din     = 8'h00;
    repeat (3) step();
    checkOutput("t1_rst_out_a",  32'(dout_a), 32'hFF);
    checkOutput("t1_rst_fall_a", 32'(fall_a), 32'h00);
    checkOutput("t1_rst_out_b",  32'(dout_b), 32'h00);

    nrst_in = 1'b1;
    step();
    step();
    checkOutput("t1_out_a_e2",  32'(dout_a), 32'hFF);
    step();
    checkOutput("t1_out_a_e3",  32'(dout_a), 32'h00);
    checkOutput("t1_fall_a_e3", 32'(fall_a), 32'hFF);
    step();
    checkOutput("t1_fall_a_e4", 32'(fall_a), 32'h00);

    din = 8'h01;
    repeat (6) step();
    checkOutput("t2_out_b_e6",  32'(dout_b), 32'h00);
    step();
    checkOutput("t2_out_b_e7",  32'(dout_b), 32'h01);
    checkOutput("t2_rise_b_e7", 32'(rise_b), 32'h01);
    checkOutput("t2_any_b_e7",  32'(any_b),  32'h1);
    step();
    checkOutput("t2_rise_b_e8", 32'(rise_b), 32'h00);
    checkOutput("t2_any_b_e8",  32'(any_b),  32'h0);

    din = 8'h09;
    repeat (3) step();
    din = 8'h01;
    repeat (10) step();
    checkOutput("t3_glitch_out_b", 32'(dout_b), 32'h01);
    din = 8'h09;
    repeat (6) step();
    checkOutput("t3_hold_out_b", 32'(dout_b), 32'h01);
    step();
    checkOutput("t3_acc_out_b",  32'(dout_b), 32'h09);
    checkOutput("t3_acc_rise_b", 32'(rise_b), 32'h08);

    step();
    step();
    din = 8'h0A;
    step();
    step();
    checkOutput("t4_rise_a_e2", 32'(rise_a), 32'h00);
    step();
    checkOutput("t4_rise_a_e3", 32'(rise_a), 32'h02);
    checkOutput("t4_fall_a_e3", 32'(fall_a), 32'h01);
    checkOutput("t4_any_a_e3",  32'(any_a),  32'h1);

    repeat (10) step();
    din = 8'hF0;
    repeat (5) step();
    nrst_in = 1'b0;
    step();
    checkOutput("t5_rst_out_b",  32'(dout_b), 32'h00);
    checkOutput("t5_rst_rise_b", 32'(rise_b), 32'h00);
    checkOutput("t5_rst_fall_b", 32'(fall_b), 32'h00);
    checkOutput("t5_rst_out_a",  32'(dout_a), 32'hFF);
    nrst_in = 1'b1;
    repeat (6) step();
    checkOutput("t5_out_b_e6",  32'(dout_b), 32'h00);
    step();
    checkOutput("t5_out_b_e7",  32'(dout_b), 32'hF0);
    checkOutput("t5_rise_b_e7", 32'(rise_b), 32'hF0);

    repeat (4) step();
    for (int n = 0; n < 20; n++) begin
      din = din ^ 8'h80;
      step();
      checkOutput("tog_out_b7", 32'(dout_b[7]), 32'h1);
      checkOutput("tog_any_b",  32'(any_b),     32'h0);
    end

    nrst_in = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
